// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/ready handshake and flush.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [2:0] {
    F_MUL    = 3'b000, F_MULH = 3'b001,
    F_MULHSU = 3'b010, F_MULHU = 3'b011,
    F_DIV    = 3'b100, F_DIVU = 3'b101,
    F_REM    = 3'b110, F_REMU = 3'b111
  } muldiv_funct3_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_n;
  muldiv_funct3_t     op;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   bmag;
  logic               neg_a, neg_b;
  logic [CW-1:0]      cnt;

  logic             sa, sb, in_na, in_nb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, div_zero, ovf, special, fast;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (funct3_i)
      3'b001, 3'b100, 3'b110: begin sa = 1'b1; sb = 1'b1; end
      3'b010:                 sa = 1'b1;
      default:                ;
    endcase
  end

  assign in_na  = sa & a_i[WIDTH-1];
  assign in_nb  = sb & b_i[WIDTH-1];
  assign a_mag  = in_na ? -a_i : a_i;
  assign b_mag  = in_nb ? -b_i : b_i;
  assign ready_o = (state == IDLE);
  assign accept = start_i & ready_o & ~flush_i;

  assign div_zero = funct3_i[2] & (b_i == '0);
  assign ovf = (funct3_i == 3'b100 || funct3_i == 3'b110)
             & (a_i == {1'b1, {(WIDTH-1){1'b0}}})
             & (&b_i);
  assign special = div_zero | ovf;

`ifdef MULDIV_FAST_MUL_EN
  assign fast = ~funct3_i[2];
`else
  assign fast = 1'b0;
`endif

  // acc holds {remainder/product-high, quotient/product-low}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_t;
  logic               div_ge;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, bmag} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_t    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = div_t >= {1'b0, bmag};
    div_r    = div_t[WIDTH-1:0] - bmag;
    div_next = {div_ge ? div_r : div_t[WIDTH-1:0],
                acc[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot, remv, res;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, acc[WIDTH-1:0]}
         * {{WIDTH{1'b0}}, bmag};
`else
    prod = acc;
`endif
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quot   = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remv   = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res    = '0;
    unique case (op)
      F_MUL:                      res = prod_s[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU:  res = prod_s[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU:              res = quot;
      F_REM, F_REMU:              res = remv;
      default:                    res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_n = (special | fast) ? FIX : CALC;
        CALC: if (cnt == LAST) state_n = FIX;
        FIX:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= F_MUL;
      acc      <= '0;
      bmag     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state  <= state_n;
      done_o <= 1'b0;
      if (accept) begin
        op   <= muldiv_funct3_t'(funct3_i);
        cnt  <= '0;
        bmag <= b_mag;
        if (special) begin
          // preload final quotient/remainder, no sign fix-up
          neg_a <= 1'b0;
          neg_b <= 1'b0;
          acc   <= div_zero ? {a_i, {WIDTH{1'b1}}}
                            : {{WIDTH{1'b0}}, a_i};
        end else begin
          neg_a <= in_na;
          neg_b <= in_nb;
          acc   <= {{WIDTH{1'b0}}, a_mag};
        end
      end else if (state == CALC && !flush_i) begin
        acc <= op[2] ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !flush_i) begin
        result_o <= res;
        done_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed + random ops
// against an arithmetic reference model, plus handshake/flush/reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        ready_o, done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .ready_o(ready_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a,
                                        logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ov;
    sa = a;
    sb = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (f == 3'd1 || f == 3'd2) ea = {{32{a[31]}}, a};
    if (f == 3'd1) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(logic [2:0] f, logic [31:0] a,
                                 logic [31:0] b);
    if (!f[2]) return MLAT;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == '1)
      return 1;
    return 33;
  endfunction

  // Issues at the current cycle; returns just after the done edge.
  task automatic do_op(string tag, logic [2:0] f, logic [31:0] a,
                       logic [31:0] b, logic [31:0] want);
    int n;
    start_i = 1'b1;
    funct3_i = f;
    a_i = a;
    b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      if (ready_o !== 1'b0 || done_o !== 1'b0) begin
        check({tag, "_busy"}, {30'b0, ready_o, done_o}, 32'd0);
      end
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        n = k;
        break;
      end
    end
    check({tag, "_lat"}, n, exp_lat(f, a, b));
    check({tag, "_res"}, result_o, want);
    check({tag, "_model"}, result_o, model(f, a, b));
    check({tag, "_rdy"}, ready_o, 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    int n;
    rst = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    funct3_i = 3'd0;
    a_i = '0;
    b_i = '0;
    #12;
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("done_pulse", done_o, 1'b0);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhu2", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("div", 3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    do_op("rem", 3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    do_op("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem0", 3'd6, 32'd5, 32'd0, 32'd5);
    do_op("remu0", 3'd7, 32'd5, 32'd0, 32'd5);
    do_op("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1;

    // start held high through a divu: one acceptance only
    start_i = 1'b1;
    funct3_i = 3'd5;
    a_i = 32'd100;
    b_i = 32'd7;
    @(posedge clk); #1;
    a_i = 32'd50;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        n = k;
        break;
      end
    end
    start_i = 1'b0;
    check("hold_lat", n, 33);
    check("hold_res", result_o, 32'd14);
    @(posedge clk); #1;
    check("hold_once", {ready_o, done_o}, 2'b10);

    // start with flush in IDLE is ignored
    start_i = 1'b1;
    flush_i = 1'b1;
    funct3_i = 3'd0;
    a_i = 32'd9;
    b_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    check("sf_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    check("sf_done", {ready_o, done_o}, 2'b10);
    check("sf_result", result_o, 32'd14);

    // flush at E10 of a div
    held = result_o;
    start_i = 1'b1;
    funct3_i = 3'd4;
    a_i = 32'd1000;
    b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(posedge clk); #1;
    check("fl_ready", ready_o, 1'b1);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) n++;
    end
    check("fl_nodone", n, 0);
    check("fl_result", result_o, held);

    // async reset mid-CALC
    start_i = 1'b1;
    funct3_i = 3'd3;
    a_i = 32'hFFFF_0000;
    b_i = 32'h1234_5678;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_ready", ready_o, 1'b1);
    check("ar_done", done_o, 1'b0);
    check("ar_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("mul34", 3'd0, 32'd3, 32'd4, 32'd12);

    // randomized ops, back-to-back
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      int pick;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) b = '0;
      if (pick == 1) begin a = 32'h8000_0000; b = '1; end
      if (pick == 2) b = $urandom_range(1, 20);
      if (pick == 3) a = -a;
      do_op("rand", f, a, b, model(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
